// File: rtl/up_counter_pkg.sv
// up_counter_pkg: shared state encoding and mode constants for the up counter
package up_counter_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [1:0] MODE_WRAP = 2'b00, MODE_SAT = 2'b01, MODE_ONESHOT = 2'b10;
endpackage

// File: rtl/up_counter_next.sv
// up_counter_next: next count, next state and event decode for the up counter
module up_counter_next import up_counter_pkg::*; #(
   parameter int N = 5,
   parameter int MODULUS = 32
) (
   input logic [N-1:0] counter,
   input state_t state,
   input logic en,
   input logic start,
   input logic stop,
   input logic load,
   input logic [N-1:0] load_val,
   input logic [1:0] mode,
   output logic [N-1:0] counter_nx,
   output state_t state_nx,
   output logic wrap_nx,
   output logic done_nx,
   output logic ovf_set
);
   localparam logic [N-1:0] MAX = N'(MODULUS - 1);
   logic go, inc, term;
   always_comb begin
      go = start && !stop;
      term = counter == MAX;
      // load suppresses every terminal-count side effect
      inc = state == RUN && !stop && en && !load;
      wrap_nx = inc && term && (mode == MODE_WRAP || mode == 2'b11);
      done_nx = inc && term && mode == MODE_ONESHOT;
      ovf_set = inc && term && mode == MODE_SAT;
      counter_nx = load ? (load_val > MAX ? MAX : load_val)
                 : state == DONE && go ? '0
                 : inc && !term ? counter + 1'b1
                 : wrap_nx ? '0 : counter;
      state_nx = state == RUN ? (stop ? IDLE : done_nx ? DONE : RUN)
               : go ? RUN : state;
   end
endmodule

// File: rtl/up_counter.sv
// up_counter: programmable-modulus up counter with wrap, saturate and one-shot modes
module up_counter import up_counter_pkg::*; #(
   parameter int N = 5,
   parameter int MODULUS = 32
) (
   input logic clk,
   input logic reset,
   input logic en,
   input logic start,
   input logic stop,
   input logic load,
   input logic [N-1:0] load_val,
   input logic [1:0] mode,
   output logic [N-1:0] counter,
   output logic tc,
   output logic wrap_pulse,
   output logic done,
   output logic busy,
   output logic ovf
);
   state_t state, state_nx;
   logic [N-1:0] counter_nx;
   logic wrap_nx, done_nx, ovf_set;
   up_counter_next #(.N(N), .MODULUS(MODULUS)) u_next (
      .counter(counter), .state(state), .en(en), .start(start), .stop(stop),
      .load(load), .load_val(load_val), .mode(mode), .counter_nx(counter_nx),
      .state_nx(state_nx), .wrap_nx(wrap_nx), .done_nx(done_nx), .ovf_set(ovf_set)
   );
   assign tc = counter == N'(MODULUS - 1);
   always_ff @(posedge clk) begin
      if (reset) begin
         counter <= '0;
         state <= IDLE;
         wrap_pulse <= 1'b0;
         done <= 1'b0;
         busy <= 1'b0;
         ovf <= 1'b0;
      end else begin
         counter <= counter_nx;
         state <= state_nx;
         wrap_pulse <= wrap_nx;
         done <= done_nx;
         busy <= state_nx == RUN;
         ovf <= ovf | ovf_set;
      end
   end
endmodule

// File: doc/up_counter.md
# up_counter

Programmable-modulus synchronous up counter with wrap, saturate and one-shot modes, run/stop control, synchronous load and terminal-count/wrap/done flags. It is the up-counting counterpart of the existing down counter and shares its clocking, reset and `counter` output convention, so the two can be swapped or paired in timer and sequencing logic.

## Interface
- `N`, 5: counter width in bits.
- `MODULUS`, 32: count range 0..MODULUS-1; legal 2 <= MODULUS <= 2^N.
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `en`  in  1: count enable; honoured only in RUN.
- `start`  in  1: IDLE/DONE -> RUN request.
- `stop`  in  1: RUN -> IDLE request.
- `load`  in  1: synchronous load of `load_val`.
- `load_val`  in  N: load value.
- `mode`  in  2: 00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
- `counter`  out  N: current count (registered).
- `tc`  out  1: terminal count, `counter == MODULUS-1` (decode of register).
- `wrap_pulse`  out  1: registered, 1 cycle, marks a wrap to 0.
- `done`  out  1: registered, 1 cycle, marks one-shot completion.
- `busy`  out  1: high while in RUN.
- `ovf`  out  1: sticky; set on a saturate-mode increment attempt at MODULUS-1.

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE, `counter`=0, `wrap_pulse`=0, `done`=0, `ovf`=0, `busy`=0, `tc`=0 (tc=1 only if MODULUS=1, which is illegal).
- IDLE: counter holds. `start` -> RUN; counter unchanged that cycle.
- RUN, `en`=1, counter < MODULUS-1: counter+1.
- RUN, `en`=1, counter = MODULUS-1:
  - wrap: counter -> 0, `wrap_pulse`=1 next cycle.
  - saturate: counter holds, `ovf` -> 1.
  - one-shot: counter holds, state -> DONE, `done`=1 next cycle.
- RUN, `en`=0: counter holds.
- RUN, `stop`: -> IDLE, counter holds. `stop` and `start` together: stop wins. `start` in RUN: ignored.
- DONE: counter holds at MODULUS-1. `start` -> counter 0, state RUN.
- `load`: accepted in any state. Counter <= `load_val`, clamped to MODULUS-1 when `load_val` >= MODULUS. Load overrides increment, wrap and the DONE restart-to-0 in the same cycle. State is unchanged, except that a start in the same cycle still moves the FSM to RUN. No `wrap_pulse`/`done`/`ovf` side effects.
- `ovf` clears only on reset.
- `mode` is sampled every cycle. A change takes effect at the next terminal event.
- Arithmetic is unsigned N-bit. The increment never exceeds MODULUS-1, so there is no raw N-bit rollover.

## Timing
- Reset has priority over everything, including a mid-run count; outputs take reset values after the edge.
- Increment, load and state transitions: 1-cycle latency, visible after the next rising edge.
- `tc` follows `counter` combinationally, with no extra latency.
- `wrap_pulse` and `done` are high in exactly the cycle in which the post-event `counter` value is first visible.
- `busy` is registered and reflects the current state.

## Structure
- Shared package: state encoding (IDLE/RUN/DONE) and mode constants (MODE_WRAP, MODE_SAT, MODE_ONESHOT).
- Single module. Next-count/clamp logic is a natural small combinational sub-block, `up_counter_next`, but it may stay inline.

## Test plan
- Wrap, N=5, MODULUS=32: reset, start, en=1 for 33 cycles -> counter 0..31, then 0. tc=1 at 31. wrap_pulse=1 only in the cycle counter returns to 0.
- Modulus-10 saturate: MODULUS=10, mode=01, run 12 cycles -> counter stops at 9, tc=1, ovf=1 from the first held cycle, stays 1 until reset.
- One-shot: MODULUS=10, mode=10 -> counter reaches 9, done pulses once, busy=0. Then start -> counter 0, busy=1.
- Load priority, MODULUS=32:
  - load_val=7 with en=1 in RUN -> counter 7, not an increment.
  - Load at counter 31 in wrap mode -> no wrap_pulse.
  - MODULUS=10, load_val=20 -> counter 9.
- Control conflicts: start+stop in IDLE -> stays IDLE. Stop in RUN at 12 -> holds 12, busy=0. en=0 in RUN -> holds.
- Reset mid-run: at counter 17, assert reset for one cycle -> counter 0, IDLE, all flags 0 at the next edge.
